// File: rtl/driver_alarm_ctrl.sv
// driver_alarm_ctrl: escalating driver-inattention alarm controller.
// Counts inattentive ticks and steps IDLE -> WARN -> ALARM -> BRAKE.
// ALARM and BRAKE stay latched until the driver is attentive and presses ack.
// Ports:
//   clk       - system clock, posedge
//   reset     - synchronous, active-low reset
//   ok_in     - attention verdict from the monitor (1 = attentive)
//   tick      - one-cycle timebase pulse
//   ack       - driver acknowledge button (pre-synchronised level)
//   level     - current stage (0 IDLE, 1 WARN, 2 ALARM, 3 BRAKE)
//   led       - warning LED (blinks on tick while in ALARM)
//   buzzer    - audible alarm
//   brake_req - brake-assist request
module driver_alarm_ctrl #(
    parameter int unsigned WARN_T  = 3,
    parameter int unsigned ALARM_T = 5,
    parameter int unsigned BRAKE_T = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ok_in,
    input  logic       tick,
    input  logic       ack,
    output logic [1:0] level,
    output logic       led,
    output logic       buzzer,
    output logic       brake_req
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned LVL_W = 2;

    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [CNT_W:0]   cmp_t;

    typedef enum logic [LVL_W-1:0] {
        IDLE  = 2'd0,
        WARN  = 2'd1,
        ALARM = 2'd2,
        BRAKE = 2'd3
    } state_t;

    localparam cmp_t WARN_LIM  = cmp_t'(WARN_T);
    localparam cmp_t ALARM_LIM = cmp_t'(ALARM_T);
    localparam cmp_t BRAKE_LIM = cmp_t'(BRAKE_T);

    state_t state_q, state_d;
    cnt_t   cnt_q, cnt_d;
    logic   led_d, buzzer_d, brake_d;
    cmp_t   limit;
    logic   hit;

    // Threshold for the stage currently being timed
    always_comb begin
        case (state_q)
            WARN:    limit = ALARM_LIM;
            ALARM:   limit = BRAKE_LIM;
            default: limit = WARN_LIM;
        endcase
    end

    // Compare one bit wider so cnt+1 never wraps before the match
    assign hit = ((cmp_t'(cnt_q) + cmp_t'(1)) == limit);

    // Next-state, counter and output decode from the next state
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        led_d    = 1'b0;
        buzzer_d = 1'b0;
        brake_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (ok_in) begin
                    cnt_d = '0;
                end else if (tick) begin
                    if (hit) begin
                        state_d = WARN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + cnt_t'(1);
                    end
                end
            end
            WARN: begin
                if (ok_in) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (tick) begin
                    if (hit) begin
                        state_d = ALARM;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + cnt_t'(1);
                    end
                end
            end
            ALARM: begin
                // Attentive without ack freezes the counter
                if (ok_in) begin
                    if (ack) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end else if (tick) begin
                    if (hit) begin
                        state_d = BRAKE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + cnt_t'(1);
                    end
                end
            end
            BRAKE: begin
                if (ok_in && ack) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        case (state_d)
            WARN: led_d = 1'b1;
            ALARM: begin
                // Blink phase starts at 1 on entry, then toggles per tick
                led_d    = (state_q != ALARM) ? 1'b1 : (led ^ tick);
                buzzer_d = 1'b1;
            end
            BRAKE: begin
                led_d    = 1'b1;
                buzzer_d = 1'b1;
                brake_d  = 1'b1;
            end
            default: led_d = 1'b0;
        endcase
    end

    // State, counter and output registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            led       <= 1'b0;
            buzzer    <= 1'b0;
            brake_req <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            led       <= led_d;
            buzzer    <= buzzer_d;
            brake_req <= brake_d;
        end
    end

    assign level = state_q;

endmodule

// File: tb/tb_driver_alarm_ctrl.sv
// Testbench for driver_alarm_ctrl: directed vector table plus randomized
// stimulus checked against a stage/tick-count reference model.
module tb_driver_alarm_ctrl;

    localparam int unsigned P_WARN  = 3;
    localparam int unsigned P_ALARM = 5;
    localparam int unsigned P_BRAKE = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       ok_in = 1'b0;
    logic       tick = 1'b0;
    logic       ack = 1'b0;
    logic [1:0] level;
    logic       led, buzzer, brake_req;

    int tests = 0;
    int fails = 0;

    driver_alarm_ctrl #(
        .WARN_T (P_WARN),
        .ALARM_T(P_ALARM),
        .BRAKE_T(P_BRAKE)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ok_in    (ok_in),
        .tick     (tick),
        .ack      (ack),
        .level    (level),
        .led      (led),
        .buzzer   (buzzer),
        .brake_req(brake_req)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit rst_n;
        bit ok;
        bit tk;
        bit ak;
        int exp_level;
        bit exp_led;
        bit exp_buz;
        bit exp_brk;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input bit r, input bit o, input bit t, input bit a,
                                input int lv, input bit ld);
        vec_t v;
        v.rst_n     = r;
        v.ok        = o;
        v.tk        = t;
        v.ak        = a;
        v.exp_level = lv;
        v.exp_led   = ld;
        v.exp_buz   = (lv >= 2);
        v.exp_brk   = (lv == 3);
        vecs.push_back(v);
    endfunction

    // Twelve inattentive ticks from IDLE with counter at 0: ends in BRAKE
    function automatic void add_escalate12();
        for (int k = 1; k <= 2; k++) add(1, 0, 1, 0, 0, 0);
        for (int k = 3; k <= 7; k++) add(1, 0, 1, 0, 1, 1);
        add(1, 0, 1, 0, 2, 1);
        add(1, 0, 1, 0, 2, 0);
        add(1, 0, 1, 0, 2, 1);
        add(1, 0, 1, 0, 2, 0);
        add(1, 0, 1, 0, 3, 1);
    endfunction

    // Reference model: stage number, ticks spent in the stage, blink bit
    int m_lvl = 0;
    int m_cnt = 0;
    bit m_led = 0;
    int thr[3];

    task automatic model_step(input bit r, input bit o, input bit t, input bit a);
        int prev;
        if (!r) begin
            m_lvl = 0;
            m_cnt = 0;
            m_led = 0;
            return;
        end
        prev = m_lvl;
        if (o) begin
            if (m_lvl == 1 || (m_lvl >= 2 && a)) m_lvl = 0;
            if (m_lvl == 0) m_cnt = 0;
        end else if (t && m_lvl < 3) begin
            m_cnt++;
            if (m_cnt == thr[m_lvl]) begin
                m_lvl++;
                m_cnt = 0;
            end
        end
        if (m_lvl == 2) m_led = (prev != 2) ? 1'b1 : (m_led ^ t);
        else            m_led = (m_lvl != 0);
    endtask

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive_cycle(input bit r, input bit o, input bit t, input bit a);
        reset = r;
        ok_in = o;
        tick  = t;
        ack   = a;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit r, o, t, a;
        thr[0] = P_WARN;
        thr[1] = P_ALARM;
        thr[2] = P_BRAKE;

        // Reset held with inattention and ticks
        add(0, 0, 1, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0);
        // WARN after 3 ticks, ack ignored in WARN, recovery
        add(1, 0, 1, 0, 0, 0);
        add(1, 0, 1, 0, 0, 0);
        add(1, 0, 1, 0, 1, 1);
        add(1, 0, 0, 1, 1, 1);
        add(1, 1, 0, 0, 0, 0);
        // Counter cleared by an attentive cycle
        add(1, 0, 1, 0, 0, 0);
        add(1, 0, 1, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0);
        add(1, 0, 1, 0, 0, 0);
        add(1, 0, 1, 0, 0, 0);
        add(1, 0, 1, 0, 1, 1);
        add(1, 1, 1, 0, 0, 0);
        add(1, 1, 1, 0, 0, 0);
        // ALARM after 8 ticks
        for (int k = 1; k <= 2; k++) add(1, 0, 1, 0, 0, 0);
        for (int k = 3; k <= 7; k++) add(1, 0, 1, 0, 1, 1);
        add(1, 0, 1, 0, 2, 1);
        // Attentive without ack: stays, blinks, counter frozen
        for (int k = 1; k <= 10; k++) add(1, 1, 1, 0, 2, (k % 2 == 0));
        add(1, 1, 0, 0, 2, 1);
        // Three low ticks are not enough for BRAKE
        add(1, 0, 1, 0, 2, 0);
        add(1, 0, 1, 0, 2, 1);
        add(1, 0, 1, 0, 2, 0);
        add(1, 1, 0, 1, 0, 0);
        // BRAKE latch and exit
        add_escalate12();
        add(1, 1, 1, 0, 3, 1);
        add(1, 0, 1, 1, 3, 1);
        add(1, 1, 0, 1, 0, 0);
        // Reset mid-BRAKE, then counting restarts
        add_escalate12();
        add(0, 0, 1, 0, 0, 0);
        add(1, 0, 1, 0, 0, 0);
        add(1, 0, 1, 0, 0, 0);
        add(1, 0, 1, 0, 1, 1);

        #2;
        foreach (vecs[i]) begin
            drive_cycle(vecs[i].rst_n, vecs[i].ok, vecs[i].tk, vecs[i].ak);
            check($sformatf("vec%0d_level", i), int'(level), vecs[i].exp_level);
            check($sformatf("vec%0d_led", i), int'(led), int'(vecs[i].exp_led));
            check($sformatf("vec%0d_buzzer", i), int'(buzzer), int'(vecs[i].exp_buz));
            check($sformatf("vec%0d_brake", i), int'(brake_req), int'(vecs[i].exp_brk));
        end

        // Randomized run against the reference model
        drive_cycle(0, 0, 0, 0);
        model_step(0, 0, 0, 0);
        for (int c = 0; c < 3000; c++) begin
            r = ($urandom_range(0, 299) != 0);
            o = ($urandom_range(0, 99) < 20);
            t = ($urandom_range(0, 1) == 1);
            a = ($urandom_range(0, 99) < 40);
            drive_cycle(r, o, t, a);
            model_step(r, o, t, a);
            check($sformatf("rnd%0d_level", c), int'(level), m_lvl);
            check($sformatf("rnd%0d_led", c), int'(led), int'(m_led));
            check($sformatf("rnd%0d_buzzer", c), int'(buzzer), int'(m_lvl >= 2));
            check($sformatf("rnd%0d_brake", c), int'(brake_req), int'(m_lvl == 3));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
